dmem_responder: RTL and testbench

- Target-side data memory for the load/store path; answers the load/store requests that the execute stage issues.
- Replaces the zero-latency combinational memory with a registered valid/ready request channel and a valid/ready response channel.
- Fixed, parameterised access latency, byte-lane writes and bounded backpressure.
- Intended use: the datapath stalls on req_ready/rsp_valid.

---
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data memory responder: registered valid/ready request channel, fixed-latency response, byte-lane stores.
// Define DMEM_ERR_EN to flag misaligned and out-of-range accesses through rsp_err.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned LATENCY        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned DEPTH = 1 << MEM_WORDS_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [MEM_WORDS_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic                      err_q, err_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      accept;
  logic                      req_err;
  logic [MEM_WORDS_LOG2-1:0] req_idx;
  logic                      commit;
  logic                      mem_we;
  logic                      c_we;
  logic                      c_err;
  logic [MEM_WORDS_LOG2-1:0] c_idx;
  logic [DATA_WIDTH-1:0]     c_wdata;
  logic [3:0]                c_be;

  assign req_idx = req_addr[MEM_WORDS_LOG2+1:2];

`ifdef DMEM_ERR_EN
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   (req_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2+2]};
  assign req_err = 1'b0;
`endif

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With single-cycle latency the commit coincides with the accept edge, so use the live request.
  always_comb begin
    if (LATENCY == 1) begin
      c_we    = req_we;
      c_err   = req_err;
      c_idx   = req_idx;
      c_wdata = req_wdata;
      c_be    = req_be;
    end else begin
      c_we    = we_q;
      c_err   = err_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_err;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = c_err;
      rsp_rdata_d = (c_we || c_err) ? '0 : mem[c_idx];
    end
  end

  assign mem_we = commit && c_we && !c_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    err_q   <= err_d;
  end

  // A reset on the commit edge abandons the store.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, backpressure/reset/latency-1 sequences, randomized model check.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_1, req_ready_1, req_we_1;
  logic [31:0] req_addr_1, req_wdata_1;
  logic [3:0]  req_be_1;
  logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
  logic [31:0] rsp_rdata_1;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS_LOG2(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS_LOG2(10), .LATENCY(1)) u_dut_1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
    .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_be(req_be_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] m_mem   [1024];
  logic [3:0]  m_known [1024];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input logic [31:0] erd, input logic eer);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.be = be; v.exp_rdata = erd; v.exp_err = eer;
    return v;
  endfunction

  function automatic logic m_err(input logic [31:0] a);
    return ERR_EN && ((a % 4 != 0) || (a >= 32'd4096));
  endfunction

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / 4) % 1024;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic m_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int unsigned idx;
    if (m_err(addr)) return;
    idx = m_idx(addr);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        m_mem[idx][8*i +: 8] = wd[8*i +: 8];
        m_known[idx][i] = 1'b1;
      end
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int unsigned stall, input bit intrude,
                        input logic [31:0] exp_rd, input logic [31:0] mask, input logic exp_err);
    int unsigned n;
    check1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n <= 20) begin
      check1("req_ready_busy", req_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    check32("latency", n, LAT);
    check1("req_ready_resp", req_ready, 1'b0);
    check32("rsp_rdata", rsp_rdata & mask, exp_rd & mask);
    check1("rsp_err", rsp_err, exp_err);
    for (int unsigned s = 0; s < stall; s++) begin
      if (intrude) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h104; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        check1("bp_req_ready", req_ready, 1'b0);
      end
      @(posedge clk); #1;
      check1("bp_rsp_valid", rsp_valid, 1'b1);
      check32("bp_rsp_rdata", rsp_rdata & mask, exp_rd & mask);
      check1("bp_rsp_err", rsp_err, exp_err);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check1("rsp_valid_cleared", rsp_valid, 1'b0);
    check1("req_ready_back", req_ready, 1'b1);
    if (we) m_store(addr, wd, be);
  endtask

  initial begin
    logic [31:0] a, wd, erd, msk;
    logic [3:0]  be;
    logic        we, eer;
    int unsigned idx;

    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = '0;
      m_known[i] = '0;
    end

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0; req_be_1 = '0; rsp_ready_1 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check32("rst_rsp_rdata", rsp_rdata, 32'h0);
    check1("rst_rsp_err", rsp_err, 1'b0);
    check1("rst_req_ready", req_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check1("post_rst_req_ready", req_ready, 1'b1);

    vecs.push_back(mk(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h100, 32'h0,        4'hF, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 32'h0000_AA00, 4'h2, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h100, 32'h0,        4'hF, 32'hDEAD_AAEF, 1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 32'h1234_5678, 4'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h100, 32'h0,        4'hF, 32'hDEAD_AAEF, 1'b0));
    vecs.push_back(mk(1'b1, 32'h200, 32'h1234_5678, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h104, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0));
`ifdef DMEM_ERR_EN
    vecs.push_back(mk(1'b0, 32'h1000, 32'h0,        4'hF, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h102,  32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1));
`else
    vecs.push_back(mk(1'b0, 32'h1100, 32'h0, 4'hF, 32'hDEAD_AAEF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h102,  32'h0, 4'hF, 32'hDEAD_AAEF, 1'b0));
`endif
    vecs.push_back(mk(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_AAEF, 1'b0));

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, i % 2, 1'b0,
             vecs[i].exp_rdata, 32'hFFFF_FFFF, vecs[i].exp_err);
    end

    // Backpressure with an ignored store to 0x104 attempted while the response is held.
    do_req(1'b0, 32'h100, 32'h0, 4'hF, 5, 1'b1, 32'hDEAD_AAEF, 32'hFFFF_FFFF, 1'b0);
    do_req(1'b0, 32'h104, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b0);

    // Reset one edge after accepting a store: no response, no write.
    check1("mid_rst_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h1111_1111; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check1("mid_rst_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    check1("mid_rst_rsp_valid2", rsp_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check1("mid_rst_release_ready", req_ready, 1'b1);
    check1("mid_rst_no_rsp", rsp_valid, 1'b0);
    do_req(1'b0, 32'h200, 32'h0, 4'hF, 0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);

    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom % 2);
      a  = 32'(($urandom % 16) * 4 + 32'h100);
      if ($urandom % 8 == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom % 8 == 0) a = a + 32'($urandom_range(1, 4) << 12);
      wd = $urandom;
      be = 4'($urandom % 16);
      eer = m_err(a);
      if (we || eer) begin
        erd = '0;
        msk = 32'hFFFF_FFFF;
      end else begin
        idx = m_idx(a);
        erd = m_mem[idx];
        msk = '0;
        for (int i = 0; i < 4; i++) if (m_known[idx][i]) msk[8*i +: 8] = 8'hFF;
      end
      do_req(we, a, wd, be, $urandom % 3, 1'b0, erd, msk, eer);
    end

    // Single-cycle latency instance.
    check1("l1_req_ready", req_ready_1, 1'b1);
    req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 32'h004; req_wdata_1 = 32'hCAFE_F00D; req_be_1 = 4'hF;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    check1("l1_store_rsp_valid", rsp_valid_1, 1'b1);
    check32("l1_store_rdata", rsp_rdata_1, 32'h0);
    check1("l1_store_err", rsp_err_1, 1'b0);
    @(posedge clk); #1;
    check1("l1_store_done", rsp_valid_1, 1'b0);
    check1("l1_req_ready2", req_ready_1, 1'b1);
    req_valid_1 = 1'b1; req_we_1 = 1'b0;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    check1("l1_load_rsp_valid", rsp_valid_1, 1'b1);
    check32("l1_load_rdata", rsp_rdata_1, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check1("l1_load_done", rsp_valid_1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
